gt_4_reg: RTL and testbench

4-bit magnitude comparator with registered outputs: asserts `y` when operand `a` is strictly greater than operand `b`, plus companion equal/less flags. It is a leaf arithmetic block for datapath compare and branch logic. The greater-than function is built hierarchically from 2-bit greater/equal slices. All outputs are registered on one clock with one cycle of latency.

---
 rtl/gt_4_reg.sv | 92 +++++++++
 tb/tb_gt_4_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gt_4_reg.sv
// gt_4_reg: 4-bit magnitude comparator with registered gt/eq/lt flags.
// Ports: clk, reset_n (sync, active-low), in_valid, a[3:0], b[3:0] ->
//   y (a>b), eq (a==b), lt (a<b), out_valid; all outputs registered,
//   one cycle latency. Macro GT_4_SIGNED_EN selects two's-complement compare.
module gt_4_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       y,
  output logic       eq,
  output logic       lt,
  output logic       out_valid
);

  function automatic logic gt_2(
    input logic [1:0] x,
    input logic [1:0] z
  );
    return (x[1] & ~z[1]) |
           (~(x[1] ^ z[1]) & x[0] & ~z[0]);
  endfunction

  function automatic logic eq_2(
    input logic [1:0] x,
    input logic [1:0] z
  );
    return ~(x[1] ^ z[1]) & ~(x[0] ^ z[0]);
  endfunction

  logic [3:0] a_c;
  logic [3:0] b_c;

`ifdef GT_4_SIGNED_EN
  // Flipping the sign bit maps -8..7 onto 0..15 in order,
  // so the unsigned slice logic then orders signed values.
  assign a_c = {~a[3], a[2:0]};
  assign b_c = {~b[3], b[2:0]};
`else
  assign a_c = a;
  assign b_c = b;
`endif

  logic gt_hi, eq_hi, gt_lo, eq_lo;
  logic gt_c, eq_c, lt_c;

  assign gt_hi = gt_2(a_c[3:2], b_c[3:2]);
  assign eq_hi = eq_2(a_c[3:2], b_c[3:2]);
  assign gt_lo = gt_2(a_c[1:0], b_c[1:0]);
  assign eq_lo = eq_2(a_c[1:0], b_c[1:0]);

  assign gt_c = gt_hi | (eq_hi & gt_lo);
  assign eq_c = eq_hi & eq_lo;
  assign lt_c = ~gt_c & ~eq_c;

  logic y_q, eq_q, lt_q, out_valid_q;
  logic y_d, eq_d, lt_d, out_valid_d;

  // Flags hold while idle; only out_valid drops.
  always_comb begin
    y_d         = y_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_d  = gt_c;
      eq_d = eq_c;
      lt_d = lt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_q         <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gt_4_reg.sv
// tb_gt_4_reg: self-checking bench for gt_4_reg.
// Table vectors, exhaustive sweep and hand-written reset/hold sequences.
module tb_gt_4_reg;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       y, eq, lt, out_valid;

  gt_4_reg dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .y         (y),
    .eq        (eq),
    .lt        (lt),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] sb[$];
  logic [2:0] last = '0;
  logic       exp_ov;
  int         checks = 0;
  int         errors = 0;

  // {y, eq, lt}
  function automatic logic [2:0] model(
    input logic [3:0] x,
    input logic [3:0] z
  );
    int xi, zi;
`ifdef GT_4_SIGNED_EN
    xi = int'($signed(x));
    zi = int'($signed(z));
`else
    xi = int'(x);
    zi = int'(z);
`endif
    return {xi > zi, xi == zi, xi < zi};
  endfunction

  task automatic chk(
    input string      name,
    input logic [2:0] got,
    input logic [2:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic cycle(
    input logic       rn,
    input logic       v,
    input logic [3:0] ai,
    input logic [3:0] bi,
    input string      name,
    input logic [2:0] want,
    input logic       use_want
  );
    @(negedge clk);
    reset_n  = rn;
    in_valid = v;
    a        = ai;
    b        = bi;
    if (rn && v) sb.push_back(model(ai, bi));
    @(posedge clk);
    #1;
    if (!rn) begin
      sb.delete();
      last   = '0;
      exp_ov = 1'b0;
    end else begin
      exp_ov = v;
    end
    chk({name, "/ov"}, {2'b0, out_valid}, {2'b0, exp_ov});
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s/sb: got valid expected none queued", name);
      end else begin
        last = sb.pop_front();
      end
      checks++;
      if ($countones({y, eq, lt}) != 1) begin
        errors++;
        $display("FAIL %s/onehot: got %b expected one-hot",
                 name, {y, eq, lt});
      end
    end
    chk(name, {y, eq, lt}, last);
    if (use_want) chk({name, "/tbl"}, {y, eq, lt}, want);
  endtask

  initial begin
    tbl.push_back('{4'd0,  4'd0,  3'b010});
    tbl.push_back('{4'd0,  4'd1,  3'b001});
    tbl.push_back('{4'd3,  4'd2,  3'b100});
    tbl.push_back('{4'd3,  4'd3,  3'b010});
    tbl.push_back('{4'd2,  4'd4,  3'b001});
    tbl.push_back('{4'd6,  4'd5,  3'b100});
    tbl.push_back('{4'd6,  4'd7,  3'b001});
    tbl.push_back('{4'd9,  4'd8,  3'b100});
    tbl.push_back('{4'd9,  4'd10, 3'b001});
    tbl.push_back('{4'd12, 4'd11, 3'b100});
    tbl.push_back('{4'd12, 4'd13, 3'b001});
    tbl.push_back('{4'd15, 4'd14, 3'b100});
    tbl.push_back('{4'd15, 4'd15, 3'b010});
`ifdef GT_4_SIGNED_EN
    tbl.push_back('{4'b1000, 4'b0111, 3'b001});
    tbl.push_back('{4'b0000, 4'b1111, 3'b100});
    tbl.push_back('{4'b1111, 4'b0001, 3'b001});
`else
    tbl.push_back('{4'b1000, 4'b0111, 3'b100});
    tbl.push_back('{4'b0000, 4'b1111, 3'b001});
    tbl.push_back('{4'b1111, 4'b0001, 3'b100});
`endif

    // reset dominates a valid input
    cycle(1'b0, 1'b1, 4'hf, 4'h0, "rst0", 3'b000, 1'b1);
    cycle(1'b0, 1'b1, 4'hf, 4'h0, "rst1", 3'b000, 1'b1);

    // table vectors, back to back
    foreach (tbl[i])
      cycle(1'b1, 1'b1, tbl[i].a, tbl[i].b,
            $sformatf("tbl%0d", i), tbl[i].f, 1'b1);

    // hold: flags keep value while idle
    cycle(1'b1, 1'b1, 4'd5, 4'd3, "hold_v", 3'b100, 1'b1);
    cycle(1'b1, 1'b0, 4'd1, 4'd9, "hold_i", 3'b100, 1'b1);
    cycle(1'b1, 1'b0, 4'd1, 4'd9, "hold_i2", 3'b100, 1'b1);

    // reset mid-stream
    cycle(1'b1, 1'b1, 4'd9, 4'd8, "mid_v", 3'b100, 1'b1);
    cycle(1'b0, 1'b1, 4'd9, 4'd8, "mid_rst", 3'b000, 1'b1);
    cycle(1'b1, 1'b0, 4'd9, 4'd8, "mid_idle", 3'b000, 1'b1);
    cycle(1'b1, 1'b1, 4'd3, 4'd3, "mid_rec", 3'b010, 1'b1);

    // exhaustive
    for (int i = 0; i < 256; i++)
      cycle(1'b1, 1'b1, 4'(i >> 4), 4'(i), "exh", 3'b000, 1'b0);

    cycle(1'b1, 1'b0, 4'd0, 4'd0, "tail", 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
